// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: raw row lines in, column drive and accepted-key
// code out. The master side is the scanner; the slave side is keypad plus decoder.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       en;

  modport master (
    input  row,
    output col,
    output key_row,
    output key_col,
    output en
  );

  modport slave (
    output row,
    input  col,
    input  key_row,
    input  key_col,
    input  en
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-hot column drive, synchronizes and
// debounces the rows, and emits one en strobe per accepted single-key press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [BW-1:0] DEB_DONE   = BW'(DEBOUNCE_CYCLES);
  localparam logic [BW-1:0] REL_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] DEB_ONE    = BW'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_row_meta;
  logic [3:0]      r_row_s;
  logic [DW-1:0]   r_dwell;
  logic [DW-1:0]   w_dwell_next;
  logic [BW-1:0]   r_deb;
  logic [BW-1:0]   w_deb_next;
  logic [3:0]      r_cand_row;
  logic [3:0]      w_cand_row_next;
  logic [3:0]      r_col;
  logic [3:0]      w_col_next;
  logic [3:0]      r_key_row;
  logic [3:0]      w_key_row_next;
  logic [3:0]      r_key_col;
  logic [3:0]      w_key_col_next;
  logic            r_en;
  logic            w_en_next;

  logic            w_onehot;
  logic            w_held_bit;
  logic [3:0]      w_col_rot;

  assign w_onehot   = (r_row_s != 4'b0000) && ((r_row_s & (r_row_s - 4'b0001)) == 4'b0000);
  assign w_held_bit = |(r_row_s & r_cand_row);
  assign w_col_rot  = {r_col[2:0], r_col[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_meta <= 4'b0000;
      r_row_s    <= 4'b0000;
      r_state    <= ST_SCAN;
      r_dwell    <= '0;
      r_deb      <= '0;
      r_cand_row <= 4'b0000;
      r_col      <= 4'b0001;
      r_key_row  <= 4'b0000;
      r_key_col  <= 4'b0000;
      r_en       <= 1'b0;
    end else begin
      r_row_meta <= bus.row;
      r_row_s    <= r_row_meta;
      r_state    <= w_state_next;
      r_dwell    <= w_dwell_next;
      r_deb      <= w_deb_next;
      r_cand_row <= w_cand_row_next;
      r_col      <= w_col_next;
      r_key_row  <= w_key_row_next;
      r_key_col  <= w_key_col_next;
      r_en       <= w_en_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_dwell_next    = r_dwell;
    w_deb_next      = r_deb;
    w_cand_row_next = r_cand_row;
    w_col_next      = r_col;
    w_key_row_next  = r_key_row;
    w_key_col_next  = r_key_col;
    w_en_next       = 1'b0;

    case (r_state)
      ST_SCAN: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_next = '0;
          if (w_onehot) begin
            w_cand_row_next = r_row_s;
            w_deb_next      = '0;
            w_state_next    = ST_DEBOUNCE;
          end else begin
            w_col_next = w_col_rot;
          end
        end else begin
          w_dwell_next = r_dwell + DWELL_ONE;
        end
      end

      // The sample edge already matched once; DEBOUNCE_CYCLES further matches accept.
      ST_DEBOUNCE: begin
        if (r_deb == DEB_DONE) begin
          w_key_row_next = r_cand_row;
          w_key_col_next = r_col;
          w_en_next      = 1'b1;
          w_state_next   = ST_HELD;
        end else if (r_row_s != r_cand_row) begin
          w_col_next   = w_col_rot;
          w_dwell_next = '0;
          w_state_next = ST_SCAN;
        end else begin
          w_deb_next = r_deb + DEB_ONE;
        end
      end

      ST_HELD: begin
        if (!w_held_bit) begin
          w_deb_next   = '0;
          w_state_next = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (w_held_bit) begin
          w_state_next = ST_HELD;
        end else if (r_deb == REL_LAST) begin
          w_col_next   = w_col_rot;
          w_dwell_next = '0;
          w_state_next = ST_SCAN;
        end else begin
          w_deb_next = r_deb + DEB_ONE;
        end
      end

      default: begin
        w_state_next = ST_SCAN;
      end
    endcase
  end

  assign bus.col     = r_col;
  assign bus.key_row = r_key_row;
  assign bus.key_col = r_key_col;
  assign bus.en      = r_en;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a switch-matrix keypad model closes rows
// onto the driven column; expected codes and latencies are hand-computed.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  // keys[r][c] = switch at row r, column c is closed
  logic [3:0][3:0] keys;
  logic [3:0]      row_drv;

  always_comb begin
    row_drv = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && kp.col[c]) row_drv[r] = 1'b1;
  end
  assign kp.row = row_drv;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kp)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   en_cnt   = 0;
  int   dbl_cnt  = 0;
  logic prev_en  = 1'b0;

  always @(negedge clk) begin
    if (kp.en === 1'b1) en_cnt <= en_cnt + 1;
    if (kp.en === 1'b1 && prev_en === 1'b1) dbl_cnt <= dbl_cnt + 1;
    prev_en <= kp.en;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end else begin
      $display("pass %s: %0h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_col(input logic [3:0] c, input int budget, input string tag);
    int k = 0;
    while (kp.col !== c && k < budget) begin
      tick(1);
      k++;
    end
    if (kp.col !== c) check_val({tag, " timeout"}, {28'd0, kp.col}, {28'd0, c});
  endtask

  task automatic wait_en(input int budget, input string tag, output int cycles);
    cycles = 0;
    while (kp.en !== 1'b1 && cycles < budget) begin
      tick(1);
      cycles++;
    end
    check_val({tag, " en seen"}, {31'd0, kp.en}, 32'd1);
  endtask

  int         cyc;
  int         base;
  logic [3:0] er;
  logic [3:0] ec;

  initial begin
    reset = 1'b1;
    keys  = '0;
    tick(3);
    check_val("reset col", {28'd0, kp.col}, 32'h1);
    check_val("reset key_row", {28'd0, kp.key_row}, 32'h0);
    check_val("reset key_col", {28'd0, kp.key_col}, 32'h0);
    check_val("reset en", {31'd0, kp.en}, 32'h0);

    // Rotation after reset: col advances on the 4th edge of each dwell
    reset = 1'b0;
    tick(3);
    check_val("rot edge3", {28'd0, kp.col}, 32'h1);
    tick(1);
    check_val("rot edge4", {28'd0, kp.col}, 32'h2);
    tick(4);
    check_val("rot edge8", {28'd0, kp.col}, 32'h4);
    tick(4);
    check_val("rot edge12", {28'd0, kp.col}, 32'h8);
    tick(4);
    check_val("rot edge16", {28'd0, kp.col}, 32'h1);
    check_val("idle no en", en_cnt, 0);

    // Clean press of (row 0100, col 0010): en 4 + 8 + 1 cycles after col arrives
    wait_col(4'b0001, 20, "pre clean");
    base = en_cnt;
    keys[2][1] = 1'b1;
    wait_col(4'b0010, 20, "clean col");
    wait_en(40, "clean", cyc);
    check_val("clean latency", cyc, 13);
    check_val("clean key_row", {28'd0, kp.key_row}, 32'h4);
    check_val("clean key_col", {28'd0, kp.key_col}, 32'h2);
    tick(27);
    check_val("clean single en", en_cnt - base, 1);
    keys = '0;
    tick(8);
    check_val("release still frozen", {28'd0, kp.col}, 32'h2);
    wait_col(4'b0100, 6, "release resume");
    check_val("release resume col", {28'd0, kp.col}, 32'h4);

    // Press bounce inside DEBOUNCE aborts; the stable key is taken on a later pass
    wait_col(4'b0010, 20, "pre bounce");
    base = en_cnt;
    keys[3][2] = 1'b1;
    wait_col(4'b0100, 20, "bounce col");
    tick(5);
    keys[3][2] = 1'b0;
    tick(1);
    keys[3][2] = 1'b1;
    tick(1);
    keys[3][2] = 1'b0;
    tick(1);
    keys[3][2] = 1'b1;
    tick(3);
    check_val("bounce abort col", {28'd0, kp.col}, 32'h8);
    check_val("bounce no en", en_cnt - base, 0);
    wait_en(40, "bounce retry", cyc);
    check_val("bounce key_row", {28'd0, kp.key_row}, 32'h8);
    check_val("bounce key_col", {28'd0, kp.key_col}, 32'h4);

    // Release bounce while held: no second en, code unchanged
    tick(3);
    keys[3][2] = 1'b0;
    tick(1);
    keys[3][2] = 1'b1;
    tick(1);
    keys[3][2] = 1'b0;
    tick(1);
    keys[3][2] = 1'b1;
    tick(20);
    check_val("relbounce key_row", {28'd0, kp.key_row}, 32'h8);
    check_val("relbounce key_col", {28'd0, kp.key_col}, 32'h4);
    keys = '0;
    tick(20);
    check_val("relbounce single en", en_cnt - base, 1);

    // Two rows closed at the sample edge: no detection, col advances
    wait_col(4'b0001, 20, "pre multi");
    base = en_cnt;
    keys[0][1] = 1'b1;
    keys[1][1] = 1'b1;
    wait_col(4'b0010, 20, "multi col");
    tick(4);
    check_val("multi advance", {28'd0, kp.col}, 32'h4);
    tick(30);
    check_val("multi no en", en_cnt - base, 0);
    keys = '0;
    tick(4);

    // Second key on a held key's column is ignored
    base = en_cnt;
    keys[0][0] = 1'b1;
    wait_en(40, "hold00", cyc);
    check_val("hold00 key_row", {28'd0, kp.key_row}, 32'h1);
    check_val("hold00 key_col", {28'd0, kp.key_col}, 32'h1);
    tick(3);
    keys[3][0] = 1'b1;
    tick(20);
    check_val("ignored no en", en_cnt - base, 1);
    check_val("ignored key_row", {28'd0, kp.key_row}, 32'h1);
    keys = '0;
    tick(20);

    // Reset mid-hold clears outputs before the next edge; held key re-detected
    keys[1][3] = 1'b1;
    wait_en(40, "prereset", cyc);
    tick(5);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("midreset col", {28'd0, kp.col}, 32'h1);
    check_val("midreset key_row", {28'd0, kp.key_row}, 32'h0);
    check_val("midreset key_col", {28'd0, kp.key_col}, 32'h0);
    check_val("midreset en", {31'd0, kp.en}, 32'h0);
    tick(1);
    reset = 1'b0;
    base = en_cnt;
    wait_en(50, "redetect", cyc);
    check_val("redetect key_row", {28'd0, kp.key_row}, 32'h2);
    check_val("redetect key_col", {28'd0, kp.key_col}, 32'h8);
    tick(2);
    check_val("redetect single en", en_cnt - base, 1);
    keys = '0;
    tick(20);

    // All sixteen keys in turn
    base = en_cnt;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        er = 4'b0001 << r;
        ec = 4'b0001 << c;
        keys[r][c] = 1'b1;
        wait_en(40, $sformatf("key r%0d c%0d", r, c), cyc);
        check_val($sformatf("key r%0d c%0d row", r, c), {28'd0, kp.key_row}, {28'd0, er});
        check_val($sformatf("key r%0d c%0d col", r, c), {28'd0, kp.key_col}, {28'd0, ec});
        tick(2);
        keys = '0;
        tick(20);
      end
    end
    check_val("sixteen en pulses", en_cnt - base, 16);
    check_val("no back-to-back en", dbl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one column at a time and sampling the row lines. It synchronizes and debounces the row inputs and enforces one key at a time. Each accepted press produces a one-hot row/column code and a single-cycle `en` strobe. The block sits directly upstream of the keypad decoder, whose `row`, `col` and `en` inputs it drives from `key_row`, `key_col` and `en`.

## Interface
- `SCAN_DIV`, default 4: cycles each column is driven; minimum 2.
- `DEBOUNCE_CYCLES`, default 8: consecutive stable samples required for press and for release; minimum 1.
- `clk`  in  1  the single clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `row`  in  4  raw keypad row lines; active-high (pressed = 1); asynchronous to `clk`.
- `col`  out  4  one-hot column drive; active-high.
- `key_row`  out  4  one-hot row of the last accepted key.
- `key_col`  out  4  one-hot column of the last accepted key.
- `en`  out  1  one-cycle strobe; `key_row`/`key_col` are valid and new in that cycle.

## Operation
- **Synchronizer.** `row` passes through a 2-flop synchronizer to give `row_s`. All decisions use `row_s` only.
- **Reset values.** `col`=0001, `key_row`=0000, `key_col`=0000, `en`=0. State is SCAN, and the dwell and debounce counters are 0. The synchronizer flops reset to 0000.
- **Column rotation.** Order is 0001→0010→0100→1000→0001. `col` advances only from SCAN at the end of a dwell, or on leaving RELEASE.
- **SCAN.**
  - The dwell counter counts 0..SCAN_DIV-1. `row_s` is sampled only when the counter equals SCAN_DIV-1.
  - If the sample has exactly one bit set: latch it as `cand_row`, freeze `col`, clear the debounce counter, go to DEBOUNCE.
  - If the sample is zero or has two or more bits set: treat it as no press. Advance `col`, reset dwell to 0, stay in SCAN.
- **DEBOUNCE.** `col` stays frozen.
  - Each cycle `row_s == cand_row` increments the counter.
  - Any mismatch (including an extra row bit) aborts to SCAN with `col` advanced, dwell 0, and no `en`.
  - When the counter reaches DEBOUNCE_CYCLES: load `key_row`=`cand_row` and `key_col`=`col`, pulse `en` for one cycle, go to HELD.
- **HELD.** `col` stays frozen.
  - Remain while `row_s[cand_row]` is 1. Other row bits are ignored, so no second key is accepted while one is held.
  - When that bit is 0, go to RELEASE with the counter cleared.
- **RELEASE.**
  - If `row_s[cand_row]` is 1, return to HELD. No new `en` is issued, so bounce on release never re-triggers.
  - Count consecutive cycles with the bit at 0. At DEBOUNCE_CYCLES, go to SCAN with `col` advanced and dwell 0.
- **Hold behaviour.** `key_row`/`key_col` hold their value until the next accepted press. `en` is never high for two consecutive cycles.
- **Counter widths.** $clog2 of the relevant maximum plus 1 where needed. Counters saturate and never wrap.

## Timing
- Input to `row_s`: 2 clock edges.
- Press to `en`, with the key stable and the correct column driven:
  - Let sample edge S be the edge on which SCAN samples the key.
  - `en` is high in cycle S+DEBOUNCE_CYCLES+1.
  - `key_row`/`key_col` change on the same edge that raises `en`.
- Worst-case column dwell before a key is seen is 4*SCAN_DIV cycles.
- Release to next scan: DEBOUNCE_CYCLES consecutive low samples. The next column then starts its dwell on the following cycle.
- `en` is registered and is not combinational from `row`.
- Reset asserted at any point, mid-debounce or mid-hold: all outputs take their reset values immediately, asynchronously. No `en` is emitted for the interrupted press. After deassertion, scanning restarts at `col`=0001 with dwell 0.
- Key held through reset: it is re-detected as a fresh press, with one `en` per the normal latency.

## Test plan
- **Reset.** Assert `reset` mid-cycle → `col`=0001, `key_row`=`key_col`=0000, `en`=0 before the next edge. After release, `col` rotates every 4 cycles (SCAN_DIV=4) with no `en` while `row`=0000.
- **Clean press and release.** Hold `row`=0100 only while `col`=0010, for 40 cycles, then release → exactly one `en` pulse, with `key_row`=0100 and `key_col`=0010 at the pulse, 9 cycles after the sample edge (DEBOUNCE_CYCLES=8). Rotation resumes to `col`=0100 after 8 low cycles.
- **Press bounce.** Toggle the row bit 3 times within the first 6 cycles of DEBOUNCE → aborts to SCAN, no `en`. Then hold stable → one `en` on a later pass.
- **Release bounce.** After acceptance, drop and re-raise the row bit for 3 cycles, then hold 20 cycles, then release cleanly → no second `en`. `key_*` remain unchanged throughout.
- **Multi-key and ignored keys.**
  - `row`=0011 at the sample edge → no detection, `col` advances.
  - While key (0001, 0001) is HELD, add `row` bit 1000 → ignored, no `en`.
- **All 16 keys.** Press each key in turn with release between presses → 16 `en` pulses. Each pulse carries the matching one-hot `key_row`/`key_col` pair.
